fp_mul_pipe: RTL
================

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 Parameter EXP_W, default 8, sets the exponent field width; legal range 4..11.
REQ-002 Parameter MAN_W, default 23, sets the stored mantissa field width; legal range 4..52.
REQ-003 Derived W = 1+EXP_W+MAN_W and BIAS = 2^(EXP_W-1)-1 shall be localparams, not ports or overridable parameters.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  block can accept an operand pair this cycle.
REQ-008 a_operand  input  W  IEEE-style operand A: sign, exponent, mantissa.
REQ-009 b_operand  input  W  operand B, same format as A.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 result  output  W  packed product.
REQ-013 Exception, Overflow, Underflow  output  1 each  per-result flags, qualified by out_valid.
REQ-014 flag_clr  input  1  clears the sticky flags.
REQ-015 sticky_flags  output  3  OR-accumulation of {Exception,Overflow,Underflow} over every accepted result.

Function
REQ-016 Pipeline depth shall be 3 register stages: S1 unpack/sign/exponent sum/special-case, S2 full (MAN_W+1)x(MAN_W+1) mantissa product, S3 normalise/round/pack.
REQ-017 Advance enable shall be en = !out_valid | out_ready; all stages advance together when en=1 and hold otherwise.
REQ-018 in_ready shall equal en; a transfer occurs when in_valid & in_ready.
REQ-019 Latency shall be exactly 3 cycles from transfer to out_valid with out_ready held high; throughput 1 per cycle; bubbles are not collapsed.
REQ-020 result and the flags shall stay stable while out_valid=1 and out_ready=0.
REQ-021 The result sign shall be a_sign XOR b_sign for every case except NaN.
REQ-022 Exponent arithmetic shall use EXP_W+2 signed bits: e = ea+eb-BIAS+norm, where norm=1 when product bit 2*MAN_W+1 is set.
REQ-023 A field with exponent 0 (zero or subnormal) shall be treated as zero; subnormal outputs are never produced.
REQ-024 NaN input, or Inf times zero, shall give canonical quiet NaN: sign 0, exponent all ones, mantissa MSB 1, remaining bits 0; Exception=1.
REQ-025 Inf times nonzero finite shall give signed Inf with Exception=1 and Overflow=0.
REQ-026 Zero times finite shall give signed zero with all flags 0.
REQ-027 If e >= 2^EXP_W-1 after rounding, the result shall be signed Inf with Overflow=1.
REQ-028 If e <= 0, the result shall be signed zero with Underflow=1.
REQ-029 A rounding carry-out of the mantissa shall increment e, and the overflow check shall use the incremented value.
REQ-030 sticky_flags shall OR in the flags on each out_valid & out_ready cycle.
REQ-031 flag_clr shall clear sticky_flags; clear takes priority over a simultaneous set.

Reset
REQ-032 While rst_n=0: stage valid bits 0, out_valid 0, sticky_flags 0, result 0, flags 0.
REQ-033 in_ready shall read 1 during and after reset.
REQ-034 Reset mid-operation shall discard all in-flight operands; no result shall emerge after release.

Configuration
REQ-035 Macro FP_MUL_RNE_EN defined: round-to-nearest-even using guard, round and sticky bits of the product.
REQ-036 Macro FP_MUL_RNE_EN undefined: truncate (round toward zero); guard, round and sticky logic are absent; latency unchanged.

Verification
REQ-037 Defaults, 0x3FC00000 x 0x40000000 -> 0x40400000, flags 0, out_valid exactly 3 cycles after transfer.
REQ-038 0x3FC00001 x 0x3FC00001 -> 0x40100002 with FP_MUL_RNE_EN, 0x40100001 without.
REQ-039 0x7F000000 x 0x7F000000 -> 0x7F800000, Overflow=1; 0x00800000 x 0x00800000 -> 0x00000000, Underflow=1.
REQ-040 0x7F800000 x 0x00000000 -> 0x7FC00000, Exception=1; sticky_flags=3'b100 until a flag_clr pulse returns 3'b000.
REQ-041 Backpressure: out_ready=0, 4 back-to-back inputs -> 3 accepted, in_ready=0, result stable; release out_ready -> 3 results in order, no loss or duplication.
REQ-042 rst_n pulsed low with 2 operands in flight -> out_valid=0 and stays 0 with no result emerging until new input; EXP_W=5, MAN_W=10 run: 0x3C00 x 0x4000 -> 0x4000.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage IEEE-style multiplier with flush-to-zero and sticky flags.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_operand,
  input  logic [W-1:0] b_operand,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         Exception,
  output logic         Overflow,
  output logic         Underflow,
  input  logic         flag_clr,
  output logic [2:0]   sticky_flags
);
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int EW = EXP_W + 2;
`ifdef FP_MUL_RNE_EN
  localparam int PW = 2*MAN_W + 2;
`else
  localparam int PW = MAN_W + 2;
`endif
  localparam int L = PW - MAN_W - 2;
  localparam logic [1:0] K_NUM = 2'd0, K_ZERO = 2'd1, K_INF = 2'd2, K_NAN = 2'd3;
  logic en, v1, v2, s1, s2;
  logic [1:0] k_in, k1, k2;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_z, b_z, a_i, b_i, a_n, b_n;
  logic signed [EW-1:0] e1, e2, e3;
  logic [MAN_W:0] m1a, m1b;
  logic [2*MAN_W+1:0] prod;
  logic [PW-1:0] p2;
  logic norm, inc, ovf_n, unf_n, exc_n, o_n, u_n;
  logic [MAN_W-1:0] frac;
  logic [MAN_W:0] fr;
  logic [W-1:0] res_n;
  assign en = !out_valid | out_ready;
  assign in_ready = en;
  assign {ea, fa} = a_operand[W-2:0];
  assign {eb, fb} = b_operand[W-2:0];
  assign a_z = ea == '0;
  assign b_z = eb == '0;
  assign a_i = &ea & ~|fa;
  assign b_i = &eb & ~|fb;
  assign a_n = &ea & |fa;
  assign b_n = &eb & |fb;
  assign k_in = (a_n | b_n | (a_i & b_z) | (b_i & a_z)) ? K_NAN
              : (a_i | b_i) ? K_INF
              : (a_z | b_z) ? K_ZERO : K_NUM;
  assign prod = m1a * m1b;
  // Only the bits rounding needs are carried into the last stage.
  assign norm = p2[PW-1];
  assign frac = norm ? p2[PW-2:L+1] : p2[PW-3:L];
`ifdef FP_MUL_RNE_EN
  logic g, st;
  assign g = norm ? p2[L] : p2[L-1];
  assign st = norm ? |p2[L-1:0] : |p2[L-2:0];
  assign inc = g & (st | frac[0]);
`else
  assign inc = 1'b0;
`endif
  assign fr = {1'b0, frac} + (MAN_W+1)'(inc);
  assign e3 = e2 + EW'(norm) + EW'(fr[MAN_W]);
  assign ovf_n = !e3[EW-1] && e3 >= EW'(2**EXP_W - 1);
  assign unf_n = e3[EW-1] || e3 == '0;
  assign exc_n = k2 == K_NAN || k2 == K_INF;
  assign o_n = k2 == K_NUM && ovf_n;
  assign u_n = k2 == K_NUM && !ovf_n && unf_n;
  assign res_n = k2 == K_NAN ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}}
               : (k2 == K_INF || o_n) ? {s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
               : (k2 == K_ZERO || u_n) ? {s2, {(W-1){1'b0}}}
               : {s2, e3[EXP_W-1:0], fr[MAN_W-1:0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      k1 <= K_NUM;
      e1 <= '0;
      m1a <= '0;
      m1b <= '0;
      v2 <= 1'b0;
      s2 <= 1'b0;
      k2 <= K_NUM;
      e2 <= '0;
      p2 <= '0;
      out_valid <= 1'b0;
      result <= '0;
      Exception <= 1'b0;
      Overflow <= 1'b0;
      Underflow <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      s1 <= a_operand[W-1] ^ b_operand[W-1];
      k1 <= k_in;
      e1 <= EW'(ea) + EW'(eb) - EW'(BIAS);
      m1a <= {1'b1, fa};
      m1b <= {1'b1, fb};
      v2 <= v1;
      s2 <= s1;
      k2 <= k1;
      e2 <= e1;
      p2 <= PW'(prod >> (2*MAN_W + 2 - PW));
      out_valid <= v2;
      result <= res_n;
      Exception <= exc_n;
      Overflow <= o_n;
      Underflow <= u_n;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_flags <= '0;
    else if (flag_clr) sticky_flags <= '0;
    else if (out_valid && out_ready) sticky_flags <= sticky_flags | {Exception, Overflow, Underflow};
  end
endmodule
